// File: rtl/if_id_buf_pkg.sv
// Shared constants and types for the IF->ID instruction buffer.
// These values mirror the NOP, zero, no-interrupt and hold codes used across the pipeline.
package if_id_buf_pkg;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [7:0]  INT_NONE  = 8'h00;

  localparam int unsigned HOLD_FLAG_W = 3;
  typedef logic [HOLD_FLAG_W-1:0] hold_flag_t;
  localparam hold_flag_t HOLD_IF = 3'b010;

  // Any hold code at or above the IF level freezes the decode-side pop.
  function automatic logic hold_blocks_pop(input hold_flag_t flag);
    return (flag >= HOLD_IF);
  endfunction

endpackage

// File: rtl/gen_ring_mem.sv
// DEPTH x W register array with one write port and one combinational read port.
// The array is not reset; occupancy tracking lives in the owner.
module gen_ring_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buf.sv
// IF->ID stage buffer: DEPTH-entry FIFO ring with valid/ready on both sides,
// flushed on redirect; decode-side pop is gated by the pipeline hold code.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  hold_flag_t                   hold_flag_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [INST_W-1:0]            inst_i,
  input  logic [ADDR_W-1:0]            inst_addr_i,
  input  logic [INT_W-1:0]             int_flag_i,
  input  logic                         qed_vld_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [INST_W-1:0]            inst_o,
  output logic [ADDR_W-1:0]            inst_addr_o,
  output logic [INT_W-1:0]             int_flag_o,
  output logic                         qed_vld_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = 1 + INT_W + ADDR_W + INST_W;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          hold_en;
  logic          push;
  logic          pop;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign hold_en = hold_blocks_pop(hold_flag_i);

  // Readiness depends only on registered occupancy, never on out_ready_i.
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;

  assign push = in_valid_i & in_ready_o & !flush_i;
  assign pop  = out_valid_o & out_ready_i & !hold_en & !flush_i;

  assign wdata = {qed_vld_i, int_flag_i, inst_addr_i, inst_i};

  gen_ring_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Empty reads are masked so stale array contents never leave the block.
  assign inst_o      = empty ? INST_W'(INST_NOP)  : rdata[INST_W-1:0];
  assign inst_addr_o = empty ? ADDR_W'(ZERO_WORD) : rdata[INST_W +: ADDR_W];
  assign int_flag_o  = empty ? INT_W'(INT_NONE)   : rdata[INST_W+ADDR_W +: INT_W];
  assign qed_vld_o   = rdata[EW-1] & out_valid_o;
  assign count_o     = count;

endmodule
